// File: rtl/xbar_demux_n.sv
// xbar_demux_n: 1-to-N TL-UL demultiplexer.
//
// One host port fans out to N device ports. Each request is routed by
// address, and the D-channel response comes back from the device that
// received the most recent accepted request. Both channels are purely
// combinational pass-throughs, so no latency is added.
//
// Several requests may be in flight, but all of them must go to the same
// device. A request to a different device waits until every earlier
// response has returned. This keeps responses in order without any
// reorder buffering.
//
// Optional feature macro: XBAR_DEMUX_ERR_RESP_EN
//   defined   : addresses that match no device go to an internal error
//               target. It answers with d_error=1 and data 0xFFFF_FFFF.
//   undefined : addresses that match no device go to device N-1.
//
// Ports:
//   clk_i   in   clock; all state updates on the rising edge
//   rst_i   in   synchronous active-high reset
//   tl_h_i  in   host request (A channel + d_ready)
//   tl_h_o  out  host response (D channel + a_ready)
//   tl_d_o  out  per-device requests; the A payload is broadcast to all
//   tl_d_i  in   per-device responses

package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module xbar_demux_n #(
  parameter int                N              = 3,
  parameter int                MaxOutstanding = 2,
  parameter logic [N-1:0][31:0] AddrBase      = {32'h4001_0000, 32'h4000_0000, 32'h0000_0000},
  parameter logic [N-1:0][31:0] AddrMask      = {32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_FFFF}
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  tlul_pkg::tl_h2d_t          tl_h_i,
  output tlul_pkg::tl_d2h_t          tl_h_o,
  output tlul_pkg::tl_h2d_t [N-1:0]  tl_d_o,
  input  tlul_pkg::tl_d2h_t [N-1:0]  tl_d_i
);

  // Index N is reserved for the error target, so the select is sized for N+1.
  localparam int SelW = $clog2(N + 1);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

`ifdef XBAR_DEMUX_ERR_RESP_EN
  localparam logic [SelW-1:0] ErrIdx  = SelW'(N);
  localparam logic [SelW-1:0] DfltIdx = ErrIdx;
`else
  localparam logic [SelW-1:0] DfltIdx = SelW'(N - 1);
`endif

  logic [CntW-1:0]   r_count;
  logic [SelW-1:0]   r_pend_sel;

  logic [SelW-1:0]   w_sel;
  logic              w_busy;
  logic              w_stall;
  logic              w_tgt_a_ready;
  logic              w_a_ready;
  logic              w_a_fire;
  logic              w_d_fire;
  tlul_pkg::tl_d2h_t w_rsp;

`ifdef XBAR_DEMUX_ERR_RESP_EN
  // state    | meaning
  // ERR_IDLE | ready to accept an unmapped request
  // ERR_RESP | holding the error response until the host takes it
  typedef enum logic {ERR_IDLE, ERR_RESP} err_state_e;

  err_state_e        r_err_state;
  err_state_e        w_err_state_nxt;
  logic [2:0]        r_err_op;
  logic [7:0]        r_err_src;
  logic [1:0]        r_err_size;
  logic              w_err_a_valid;
  logic              w_err_a_ready;
  logic              w_err_d_ready;
  tlul_pkg::tl_d2h_t w_err_rsp;
`endif

  // Scan from the highest index down, so the lowest matching index is
  // the one that remains.
  always_comb begin
    w_sel = DfltIdx;
    for (int i = N - 1; i >= 0; i--) begin
      if ((tl_h_i.a_address & ~AddrMask[i]) == AddrBase[i]) begin
        w_sel = SelW'(i);
      end
    end
  end

  assign w_busy  = (r_count != '0);
  assign w_stall = (r_count == CntMax) || (w_busy && (w_sel != r_pend_sel));

  always_comb begin
    w_tgt_a_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_sel == SelW'(i)) begin
        w_tgt_a_ready = tl_d_i[i].a_ready;
      end
    end
`ifdef XBAR_DEMUX_ERR_RESP_EN
    if (w_sel == ErrIdx) begin
      w_tgt_a_ready = w_err_a_ready;
    end
`endif
  end

  assign w_a_ready = !rst_i && !w_stall && w_tgt_a_ready;
  assign w_a_fire  = tl_h_i.a_valid && w_a_ready;

  // When nothing is outstanding, a response from any device is treated as
  // spurious. It is not forwarded and not acknowledged, so the counter
  // cannot underflow.
  always_comb begin
    w_rsp = '0;
    for (int i = 0; i < N; i++) begin
      if (r_pend_sel == SelW'(i)) begin
        w_rsp = tl_d_i[i];
      end
    end
`ifdef XBAR_DEMUX_ERR_RESP_EN
    if (r_pend_sel == ErrIdx) begin
      w_rsp = w_err_rsp;
    end
`endif
    if (rst_i || !w_busy) begin
      w_rsp.d_valid = 1'b0;
    end
  end

  assign w_d_fire = w_rsp.d_valid && tl_h_i.d_ready;

  always_comb begin
    tl_h_o         = w_rsp;
    tl_h_o.a_ready = w_a_ready;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      tl_d_o[i]         = tl_h_i;
      tl_d_o[i].a_valid = !rst_i && !w_stall && tl_h_i.a_valid && (w_sel == SelW'(i));
      tl_d_o[i].d_ready = !rst_i && w_busy && tl_h_i.d_ready && (r_pend_sel == SelW'(i));
    end
  end

  // The count is saturated at both ends as a guard. The stall rule
  // already keeps legal traffic inside these bounds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count    <= '0;
      r_pend_sel <= '0;
    end else begin
      if (w_a_fire) begin
        r_pend_sel <= w_sel;
      end
      if (w_a_fire && !w_d_fire && (r_count != CntMax)) begin
        r_count <= r_count + CntW'(1);
      end else if (w_d_fire && !w_a_fire && (r_count != '0)) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

`ifdef XBAR_DEMUX_ERR_RESP_EN
  assign w_err_a_valid = !rst_i && !w_stall && tl_h_i.a_valid && (w_sel == ErrIdx);
  assign w_err_d_ready = !rst_i && w_busy && tl_h_i.d_ready && (r_pend_sel == ErrIdx);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_state <= ERR_IDLE;
      r_err_op    <= '0;
      r_err_src   <= '0;
      r_err_size  <= '0;
    end else begin
      r_err_state <= w_err_state_nxt;
      if (w_err_a_valid && w_err_a_ready) begin
        r_err_op   <= tl_h_i.a_opcode;
        r_err_src  <= tl_h_i.a_source;
        r_err_size <= tl_h_i.a_size;
      end
    end
  end

  always_comb begin
    w_err_state_nxt = r_err_state;
    case (r_err_state)
      ERR_IDLE: if (w_err_a_valid) w_err_state_nxt = ERR_RESP;
      ERR_RESP: if (w_err_d_ready) w_err_state_nxt = ERR_IDLE;
      default:  w_err_state_nxt = ERR_IDLE;
    endcase
  end

  always_comb begin
    w_err_a_ready = (r_err_state == ERR_IDLE);
    w_err_rsp     = '0;
    if (r_err_state == ERR_RESP) begin
      w_err_rsp.d_valid  = 1'b1;
      w_err_rsp.d_error  = 1'b1;
      w_err_rsp.d_source = r_err_src;
      w_err_rsp.d_size   = r_err_size;
      w_err_rsp.d_opcode = (r_err_op == tlul_pkg::Get) ? tlul_pkg::AccessAckData
                                                       : tlul_pkg::AccessAck;
      w_err_rsp.d_data   = 32'hFFFF_FFFF;
    end
  end
`endif

endmodule

// File: tb/tb_xbar_demux_n.sv
// Self-checking bench for xbar_demux_n.
// Directed scenarios are followed by a randomized phase. The bench keeps a
// reference model of the routing rules, tracking the outstanding count,
// the pending target and any error capture.
module tb_xbar_demux_n;
  import tlul_pkg::*;

  localparam int N    = 3;
  localparam int MAXO = 2;
  localparam logic [N-1:0][31:0] BASE = {32'h4001_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [N-1:0][31:0] MASK = {32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_FFFF};

  logic             clk_i = 1'b0;
  logic             rst_i;
  tl_h2d_t          tl_h_i;
  tl_d2h_t          tl_h_o;
  tl_h2d_t [N-1:0]  tl_d_o;
  tl_d2h_t [N-1:0]  tl_d_i;

  always #5 clk_i = ~clk_i;

  xbar_demux_n #(
    .N(N), .MaxOutstanding(MAXO), .AddrBase(BASE), .AddrMask(MASK)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tl_h_i(tl_h_i),
    .tl_h_o(tl_h_o),
    .tl_d_o(tl_d_o),
    .tl_d_i(tl_d_i)
  );

  int checks   = 0;
  int failures = 0;

  int         m_cnt = 0;
  int         m_pend = 0;
  logic [7:0] m_err_src = '0;
  logic [2:0] m_err_op = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] addr);
    for (int i = 0; i < N; i++) begin
      if ((addr & ~MASK[i]) == BASE[i]) return i;
    end
`ifdef XBAR_DEMUX_ERR_RESP_EN
    return N;
`else
    return N - 1;
`endif
  endfunction

  // Compares every output against the model, then applies this cycle's fires.
  task automatic sample();
    int         sel;
    bit         stall, tgt_rdy, ar, hdv, afire, dfire;
    logic [31:0] hdata;
    logic       herr;
    logic [7:0] hsrc;
    logic [2:0] hop;
    @(negedge clk_i);
    check("count", 64'(dut.r_count), 64'(m_cnt));
    sel   = ref_decode(tl_h_i.a_address);
    stall = (m_cnt == MAXO) || (m_cnt != 0 && sel != m_pend);
    if (sel < N) tgt_rdy = tl_d_i[sel].a_ready;
    else         tgt_rdy = !(m_cnt != 0 && m_pend == N);
    ar = !rst_i && !stall && tgt_rdy;
    check("a_ready", 64'(tl_h_o.a_ready), 64'(ar));
    for (int j = 0; j < N; j++) begin
      check($sformatf("a_valid%0d", j), 64'(tl_d_o[j].a_valid),
            64'(!rst_i && !stall && tl_h_i.a_valid && sel == j));
      check($sformatf("d_ready%0d", j), 64'(tl_d_o[j].d_ready),
            64'(!rst_i && m_cnt != 0 && m_pend == j && tl_h_i.d_ready));
      check($sformatf("a_addr%0d", j), 64'(tl_d_o[j].a_address), 64'(tl_h_i.a_address));
    end
    if (m_pend < N) begin
      hdv   = (m_cnt != 0) && tl_d_i[m_pend].d_valid;
      hdata = tl_d_i[m_pend].d_data;
      herr  = tl_d_i[m_pend].d_error;
      hsrc  = tl_d_i[m_pend].d_source;
      hop   = tl_d_i[m_pend].d_opcode;
    end else begin
      hdv   = (m_cnt != 0);
      hdata = 32'hFFFF_FFFF;
      herr  = 1'b1;
      hsrc  = m_err_src;
      hop   = (m_err_op == Get) ? AccessAckData : AccessAck;
    end
    if (rst_i) hdv = 1'b0;
    check("d_valid", 64'(tl_h_o.d_valid), 64'(hdv));
    if (hdv) begin
      check("d_data",   64'(tl_h_o.d_data),   64'(hdata));
      check("d_error",  64'(tl_h_o.d_error),  64'(herr));
      check("d_source", 64'(tl_h_o.d_source), 64'(hsrc));
      check("d_opcode", 64'(tl_h_o.d_opcode), 64'(hop));
    end
    afire = tl_h_i.a_valid && ar;
    dfire = hdv && tl_h_i.d_ready;
    if (rst_i) begin
      m_cnt  = 0;
      m_pend = 0;
    end else begin
      if (afire) begin
        m_pend = sel;
        if (sel == N) begin
          m_err_src = tl_h_i.a_source;
          m_err_op  = tl_h_i.a_opcode;
        end
      end
      m_cnt = m_cnt + int'(afire) - int'(dfire);
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drive_a(input bit v, input logic [2:0] op, input logic [31:0] addr,
                         input logic [7:0] src);
    tl_h_i.a_valid   = v;
    tl_h_i.a_opcode  = op;
    tl_h_i.a_address = addr;
    tl_h_i.a_source  = src;
    tl_h_i.a_size    = 2'd2;
    tl_h_i.a_mask    = 4'hF;
    tl_h_i.a_data    = $urandom;
  endtask

  initial begin
    int pick;
    logic [31:0] addr;
    rst_i  = 1'b1;
    tl_h_i = '0;
    tl_d_i = '0;
    for (int j = 0; j < N; j++) tl_d_i[j].a_ready = 1'b1;
    tl_h_i.d_ready = 1'b1;
    advance();

    // Reset state.
    sample();
    check("rst_a_ready", 64'(tl_h_o.a_ready), 64'(0));
    check("rst_d_valid", 64'(tl_h_o.d_valid), 64'(0));
    advance();
    rst_i = 1'b0;
    step();

    // Get to device 0; response on the following cycle.
    drive_a(1'b1, Get, 32'h0000_0010, 8'd1);
    step();
    drive_a(1'b0, Get, 32'h0000_0010, 8'd1);
    tl_d_i[0].d_valid = 1'b1;
    tl_d_i[0].d_data  = 32'h1234_5678;
    tl_d_i[0].d_opcode = AccessAckData;
    tl_d_i[0].d_source = 8'd1;
    sample();
    check("req27_dvalid", 64'(tl_h_o.d_valid), 64'(1));
    check("req27_data",   64'(tl_h_o.d_data),  64'(32'h1234_5678));
    advance();
    tl_d_i[0].d_valid = 1'b0;
    sample();
    check("req27_cnt", 64'(dut.r_count), 64'(0));
    advance();

    // Two outstanding requests fill the slots, so a third one stalls.
    drive_a(1'b1, Get, 32'h4000_0004, 8'd2);
    step();
    step();
    sample();
    check("req28_stall", 64'(tl_h_o.a_ready), 64'(0));
    advance();
    tl_d_i[1].d_valid = 1'b1;
    tl_d_i[1].d_data  = 32'hA5A5_0001;
    step();
    tl_d_i[1].d_valid = 1'b0;
    sample();
    check("req28_accept", 64'(tl_h_o.a_ready), 64'(1));
    advance();
    drive_a(1'b0, Get, 32'h4000_0004, 8'd2);
    tl_d_i[1].d_valid = 1'b1;
    step();
    step();
    tl_d_i[1].d_valid = 1'b0;
    step();

    // A request to a different device waits for the pending response.
    drive_a(1'b1, Get, 32'h4000_0000, 8'd3);
    step();
    drive_a(1'b1, PutFullData, 32'h0000_0000, 8'd4);
    sample();
    check("req29_stall_dev0", 64'(tl_d_o[0].a_valid), 64'(0));
    advance();
    tl_d_i[1].d_valid = 1'b1;
    step();
    tl_d_i[1].d_valid = 1'b0;
    sample();
    check("req29_fwd_dev0", 64'(tl_d_o[0].a_valid), 64'(1));
    advance();
    drive_a(1'b0, PutFullData, 32'h0000_0000, 8'd4);
    tl_d_i[0].d_valid = 1'b1;
    step();
    tl_d_i[0].d_valid = 1'b0;
    step();

`ifdef XBAR_DEMUX_ERR_RESP_EN
    drive_a(1'b1, Get, 32'h8000_0000, 8'd5);
    sample();
    for (int j = 0; j < N; j++) check($sformatf("req30_noav%0d", j), 64'(tl_d_o[j].a_valid), 64'(0));
    check("req30_aready", 64'(tl_h_o.a_ready), 64'(1));
    advance();
    drive_a(1'b0, Get, 32'h8000_0000, 8'd5);
    sample();
    check("req30_dvalid", 64'(tl_h_o.d_valid),  64'(1));
    check("req30_derror", 64'(tl_h_o.d_error),  64'(1));
    check("req30_dsrc",   64'(tl_h_o.d_source), 64'(5));
    check("req30_ddata",  64'(tl_h_o.d_data),   64'(32'hFFFF_FFFF));
    advance();
    step();
`else
    drive_a(1'b1, PutFullData, 32'h8000_0000, 8'd6);
    sample();
    check("req31_dev2", 64'(tl_d_o[2].a_valid), 64'(1));
    check("req31_dev0", 64'(tl_d_o[0].a_valid), 64'(0));
    check("req31_dev1", 64'(tl_d_o[1].a_valid), 64'(0));
    advance();
    drive_a(1'b0, PutFullData, 32'h8000_0000, 8'd6);
    tl_d_i[2].d_valid = 1'b1;
    step();
    tl_d_i[2].d_valid = 1'b0;
    step();
`endif

    // Reset with two requests outstanding.
    drive_a(1'b1, Get, 32'h0000_0010, 8'd7);
    step();
    step();
    rst_i = 1'b1;
    sample();
    check("req32_rst_dvalid", 64'(tl_h_o.d_valid),    64'(0));
    check("req32_rst_av0",    64'(tl_d_o[0].a_valid), 64'(0));
    advance();
    rst_i = 1'b0;
    sample();
    check("req32_cnt",    64'(dut.r_count),     64'(0));
    check("req32_accept", 64'(tl_h_o.a_ready),  64'(1));
    advance();
    drive_a(1'b0, Get, 32'h0000_0010, 8'd7);
    tl_d_i[0].d_valid = 1'b1;
    step();
    tl_d_i[0].d_valid = 1'b0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
`ifdef XBAR_DEMUX_ERR_RESP_EN
      pick = $urandom_range(0, 2);
`else
      pick = $urandom_range(0, 3);
`endif
      case (pick)
        0:       addr = $urandom & 32'h0000_FFFF;
        1:       addr = 32'h4000_0000 | ($urandom & 32'h0000_0FFF);
        2:       addr = 32'h4001_0000 | ($urandom & 32'h0000_0FFF);
        default: addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      endcase
      drive_a(1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? Get : PutFullData,
              addr, 8'($urandom));
      tl_h_i.d_ready = 1'($urandom_range(0, 1));
      for (int j = 0; j < N; j++) begin
        tl_d_i[j].a_ready  = ($urandom_range(0, 3) != 0);
        tl_d_i[j].d_valid  = 1'($urandom_range(0, 1));
        tl_d_i[j].d_data   = $urandom;
        tl_d_i[j].d_source = 8'($urandom);
        tl_d_i[j].d_error  = 1'($urandom_range(0, 1));
        tl_d_i[j].d_opcode = ($urandom_range(0, 1) != 0) ? AccessAckData : AccessAck;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
